cache_cmd_feeder: RTL and testbench
===================================

CACHE_CMD_FEEDER -- requirements
Module: cache_cmd_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  trace record present.
REQ-006 SHALL have port in_ready  output  1  feeder can accept a record this cycle.
REQ-007 SHALL have port in_command  input  5  trace command code.
REQ-008 SHALL have port in_address  input  32  trace byte address.
REQ-009 SHALL have port out_valid  output  1  head record valid toward the cache.
REQ-010 SHALL have port out_ready  input  1  cache consumes head record.
REQ-011 SHALL have port out_command / out_address  output  5 / 32  head record fields.
REQ-012 SHALL have port out_tag / out_index / out_byte  output  24 / 2 / 6  head address split as [31:8] / [7:6] / [5:0].
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port rd_cnt, wr_cnt, snp_cnt, ill_cnt  output  CNT_W each  statistics.
REQ-015 SHALL have port print_pulse  output  1  one-cycle request to dump statistics.

Function
REQ-016 SHALL transfer an input record only when in_valid && in_ready at a rising edge.
REQ-017 SHALL enqueue only commands 0-6; command 8 (clear), command 9 (print), and codes 7 and 10-31 (illegal) SHALL be consumed without enqueue.
REQ-018 SHALL increment at acceptance: rd_cnt for 0 or 2; wr_cnt for 1; snp_cnt for 3-6; ill_cnt for 7 or 10-31.
REQ-019 SHALL saturate every counter at all-ones; no wrap.
REQ-020 SHALL drive print_pulse high for exactly the cycle after a command-9 acceptance.
REQ-021 SHALL implement FSM states RUN, DRAIN, CLEAR.
REQ-022 RUN: in_ready = !full; accepting command 8 SHALL go to DRAIN.
REQ-023 DRAIN: in_ready = 0; FIFO keeps draining; go to CLEAR in the cycle level==0.
REQ-024 CLEAR: lasts one cycle; in_ready = 0; all four counters SHALL be zero at its end; then RUN.
REQ-025 SHALL assert out_valid = (level != 0); out_* SHALL show the head entry, stable while out_valid && !out_ready.
REQ-026 SHALL pop the head on out_valid && out_ready.
REQ-027 SHALL have enqueue-to-out_valid latency of exactly 1 cycle with an empty FIFO; no combinational in->out bypass.
REQ-028 SHALL deassert in_ready when full, even if out_ready is high in the same cycle.
REQ-029 Push and pop in the same cycle SHALL leave level unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 SHALL leave out_* values don't-care while out_valid=0; verification SHALL ignore them.

Reset
REQ-032 rst high SHALL immediately force: state RUN, level 0, pointers 0, out_valid 0, print_pulse 0, all counters 0.
REQ-033 While rst is high, in_ready SHALL be 0.
REQ-034 After rst deasserts, in_ready SHALL be 1 on the first rising edge.
REQ-035 Reset during DRAIN or with a non-empty FIFO SHALL discard all queued records; no partial CLEAR.

Verification
REQ-036 Sequence (0,0x1000_01C0), (1,0x2000_0040), (3,0x3000_0080) with out_ready=1: same order out, first one cycle after acceptance; out_tag=0x100001, out_index=3, out_byte=0; rd/wr/snp = 1/1/1.
REQ-037 out_ready=0, push 5 records with DEPTH=4: in_ready drops after 4th, level=4, 5th held; then out_ready=1: 5th accepted, FIFO order preserved.
REQ-038 Commands 7, 12, 31: ill_cnt=3, level stays 0, out_valid never asserts.
REQ-039 Three records queued, out_ready=0, then command 8: in_ready=0 until three pops complete, one CLEAR cycle, counters read 0, in_ready returns 1.
REQ-040 Command 9: print_pulse high exactly one cycle; counters and level unchanged.
REQ-041 Force rd_cnt to 0xFFFE, send three reads: rd_cnt holds 0xFFFF; rst asserted mid-stream: all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/cache_cmd_feeder.sv
// -----------------------------------------------------------------------------
// cache_cmd_feeder
//
// Purpose:
//   Accepts cache trace records (command + byte address), filters them by
//   command class, and queues the cacheable ones (commands 0-6) in a small
//   FIFO that is presented to the cache with a valid/ready handshake. Keeps
//   saturating statistics counters per command class, raises a one-cycle
//   print request on command 9, and on command 8 drains the FIFO and then
//   clears all statistics.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   in_valid / in_ready      trace record handshake
//   in_command, in_address   trace record fields
//   out_valid / out_ready    head-of-FIFO handshake toward the cache
//   out_command, out_address head record fields
//   out_tag/out_index/out_byte  head address split [31:8] / [7:6] / [5:0]
//   level                    FIFO occupancy
//   rd_cnt, wr_cnt, snp_cnt, ill_cnt  saturating statistics counters
//   print_pulse              one-cycle request to dump statistics
// -----------------------------------------------------------------------------
module cache_cmd_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_command,
    input  logic [31:0]              in_address,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_command,
    output logic [31:0]              out_address,
    output logic [23:0]              out_tag,
    output logic [1:0]               out_index,
    output logic [5:0]               out_byte,

    output logic [$clog2(DEPTH):0]   level,

    output logic [CNT_W-1:0]         rd_cnt,
    output logic [CNT_W-1:0]         wr_cnt,
    output logic [CNT_W-1:0]         snp_cnt,
    output logic [CNT_W-1:0]         ill_cnt,
    output logic                     print_pulse
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StClear
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [LVL_W-1:0]   level_q,   level_d;
    logic [CNT_W-1:0]   rd_cnt_q,  rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q,  wr_cnt_d;
    logic [CNT_W-1:0]   snp_cnt_q, snp_cnt_d;
    logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
    logic               print_q,   print_d;

    // FIFO storage; contents are don't-care while empty, so no reset needed.
    logic [4:0]         cmd_mem  [DEPTH];
    logic [31:0]        addr_mem [DEPTH];

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    logic is_enq;
    logic is_rd;
    logic is_wr;
    logic is_snp;
    logic is_clr;
    logic is_prt;
    logic is_ill;

    always_comb begin
        is_enq = (in_command <= 5'd6);
        is_rd  = (in_command == 5'd0) || (in_command == 5'd2);
        is_wr  = (in_command == 5'd1);
        is_snp = (in_command >= 5'd3) && (in_command <= 5'd6);
        is_clr = (in_command == 5'd8);
        is_prt = (in_command == 5'd9);
        is_ill = (in_command == 5'd7) || (in_command >= 5'd10);
    end

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic full;
    logic accept;
    logic push;
    logic pop;

    always_comb begin
        full      = (level_q == LVL_W'(DEPTH));
        // rst gates in_ready directly so it reads 0 for the whole reset window,
        // not just once the registers have settled.
        in_ready  = !rst && (state_q == StRun) && !full;
        out_valid = (level_q != '0);
        accept    = in_valid && in_ready;
        push      = accept && is_enq;
        pop       = out_valid && out_ready;
    end

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
        // increment wraps modulo DEPTH on its own.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM and statistics
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        snp_cnt_d = snp_cnt_q;
        ill_cnt_d = ill_cnt_q;
        print_d   = accept && is_prt;

        // Counting only happens on acceptance, which is only possible in
        // StRun, so it never collides with the clear in StClear.
        if (accept) begin
            if (is_rd) begin
                rd_cnt_d = sat_inc(rd_cnt_q);
            end
            if (is_wr) begin
                wr_cnt_d = sat_inc(wr_cnt_q);
            end
            if (is_snp) begin
                snp_cnt_d = sat_inc(snp_cnt_q);
            end
            if (is_ill) begin
                ill_cnt_d = sat_inc(ill_cnt_q);
            end
        end

        unique case (state_q)
            StRun: begin
                if (accept && is_clr) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Input is blocked; wait for the cache to empty the FIFO.
                if (level_q == '0) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                rd_cnt_d  = '0;
                wr_cnt_d  = '0;
                snp_cnt_d = '0;
                ill_cnt_d = '0;
                state_d   = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            snp_cnt_q <= '0;
            ill_cnt_q <= '0;
            print_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            snp_cnt_q <= snp_cnt_d;
            ill_cnt_q <= ill_cnt_d;
            print_q   <= print_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr_q]  <= in_command;
            addr_mem[wr_ptr_q] <= in_address;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        out_command = cmd_mem[rd_ptr_q];
        out_address = addr_mem[rd_ptr_q];
        out_tag     = out_address[31:8];
        out_index   = out_address[7:6];
        out_byte    = out_address[5:0];
        level       = level_q;
        rd_cnt      = rd_cnt_q;
        wr_cnt      = wr_cnt_q;
        snp_cnt     = snp_cnt_q;
        ill_cnt     = ill_cnt_q;
        print_pulse = print_q;
    end

endmodule

// File: tb/tb_cache_cmd_feeder.sv
module tb_cache_cmd_feeder;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int          CNT_MAX = 65535;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_command;
    logic [31:0] in_address;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_command;
    logic [31:0] out_address;
    logic [23:0] out_tag;
    logic [1:0]  out_index;
    logic [5:0]  out_byte;
    logic [2:0]  level;
    logic [15:0] rd_cnt, wr_cnt, snp_cnt, ill_cnt;
    logic        print_pulse;

    // Narrow-counter instance used only to reach saturation in a few cycles.
    logic        s_in_valid;
    logic        s_in_ready;
    logic [4:0]  s_in_command;
    logic [31:0] s_in_address;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [4:0]  s_out_command;
    logic [31:0] s_out_address;
    logic [23:0] s_out_tag;
    logic [1:0]  s_out_index;
    logic [5:0]  s_out_byte;
    logic [2:0]  s_level;
    logic [3:0]  s_rd_cnt, s_wr_cnt, s_snp_cnt, s_ill_cnt;
    logic        s_print_pulse;

    int n_vec = 0;
    int n_err = 0;

    cache_cmd_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_command(in_command), .in_address(in_address),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_command(out_command), .out_address(out_address),
        .out_tag(out_tag), .out_index(out_index), .out_byte(out_byte),
        .level(level),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .snp_cnt(snp_cnt), .ill_cnt(ill_cnt),
        .print_pulse(print_pulse)
    );

    cache_cmd_feeder #(.DEPTH(DEPTH), .CNT_W(4)) sat_dut (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_command(s_in_command), .in_address(s_in_address),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_command(s_out_command), .out_address(s_out_address),
        .out_tag(s_out_tag), .out_index(s_out_index), .out_byte(s_out_byte),
        .level(s_level),
        .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt), .snp_cnt(s_snp_cnt), .ill_cnt(s_ill_cnt),
        .print_pulse(s_print_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a record queue plus plain counters and a mode flag.
    // It holds the state the design should show during the current cycle.
    // ---------------------------------------------------------------------
    logic [4:0]  mq_cmd [$];
    logic [31:0] mq_addr[$];
    int          m_rd, m_wr, m_snp, m_ill;
    bit          m_print;
    int          m_mode;   // 0 accepting, 1 waiting for empty, 2 clearing

    task automatic m_reset();
        mq_cmd.delete();
        mq_addr.delete();
        m_rd = 0; m_wr = 0; m_snp = 0; m_ill = 0;
        m_print = 0;
        m_mode  = 0;
    endtask

    initial m_reset();

    always @(negedge clk) begin
        bit          m_rdy, m_val, acc, pp;
        logic [4:0]  c;
        logic [31:0] a;
        if (rst) m_reset();
        m_rdy = !rst && (m_mode == 0) && (mq_cmd.size() < DEPTH);
        m_val = (mq_cmd.size() != 0);
        chk("in_ready",    {31'd0, in_ready},    {31'd0, m_rdy});
        chk("out_valid",   {31'd0, out_valid},   {31'd0, m_val});
        chk("level",       {29'd0, level},       mq_cmd.size());
        chk("rd_cnt",      {16'd0, rd_cnt},      m_rd);
        chk("wr_cnt",      {16'd0, wr_cnt},      m_wr);
        chk("snp_cnt",     {16'd0, snp_cnt},     m_snp);
        chk("ill_cnt",     {16'd0, ill_cnt},     m_ill);
        chk("print_pulse", {31'd0, print_pulse}, {31'd0, m_print});
        if (m_val) begin
            a = mq_addr[0];
            chk("out_command", {27'd0, out_command}, {27'd0, mq_cmd[0]});
            chk("out_address", out_address, a);
            chk("out_tag",     {8'd0, out_tag},    a >> 8);
            chk("out_index",   {30'd0, out_index}, (a >> 6) % 4);
            chk("out_byte",    {26'd0, out_byte},  a % 64);
        end
        if (!rst) begin
            acc = in_valid && m_rdy;
            pp  = m_val && out_ready;
            c   = in_command;
            m_print = acc && (c == 5'd9);
            if (m_mode == 2) begin
                m_rd = 0; m_wr = 0; m_snp = 0; m_ill = 0;
                m_mode = 0;
            end else if (m_mode == 1 && mq_cmd.size() == 0) begin
                m_mode = 2;
            end
            if (pp) begin
                void'(mq_cmd.pop_front());
                void'(mq_addr.pop_front());
            end
            if (acc) begin
                if (c <= 5'd6) begin
                    mq_cmd.push_back(c);
                    mq_addr.push_back(in_address);
                end
                if (c == 5'd0 || c == 5'd2) begin
                    if (m_rd < CNT_MAX) m_rd++;
                end else if (c == 5'd1) begin
                    if (m_wr < CNT_MAX) m_wr++;
                end else if (c >= 5'd3 && c <= 5'd6) begin
                    if (m_snp < CNT_MAX) m_snp++;
                end else if (c == 5'd8) begin
                    m_mode = 1;
                end else if (c != 5'd9) begin
                    if (m_ill < CNT_MAX) m_ill++;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Drivers; every task is entered and left 1 time unit after a rising edge.
    // ---------------------------------------------------------------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [4:0] c, input logic [31:0] a);
        bit acc;
        int t;
        acc = 0;
        t   = 0;
        in_valid   = 1'b1;
        in_command = c;
        in_address = a;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no acceptance expected acceptance of cmd %0d", c);
        end
    endtask

    task automatic sat_reads(input int n);
        int got;
        int t;
        got = 0;
        t   = 0;
        s_in_valid = 1'b1;
        while (got < n && t < 100) begin
            @(negedge clk);
            if (s_in_ready) got++;
            @(posedge clk);
            #1;
            t++;
        end
        s_in_valid = 1'b0;
        chk("sat_accepts", got, n);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_command = '0; in_address = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_command = 5'd0; s_in_address = 32'h0000_0040;
        s_out_ready = 1'b1;

        // Reset window and release
        tick(2);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Ordered flow with immediate consumption
        out_ready = 1'b1;
        send(5'd0, 32'h1000_01C0);
        chk("lat1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat1_out_tag",   {8'd0, out_tag},    32'h0010_0001);
        chk("lat1_out_index", {30'd0, out_index}, 32'd3);
        chk("lat1_out_byte",  {26'd0, out_byte},  32'd0);
        send(5'd1, 32'h2000_0040);
        send(5'd3, 32'h3000_0080);
        tick(3);
        chk("seq_rd",  {16'd0, rd_cnt},  32'd1);
        chk("seq_wr",  {16'd0, wr_cnt},  32'd1);
        chk("seq_snp", {16'd0, snp_cnt}, 32'd1);

        // Illegal commands are counted but never queued
        send(5'd7,  32'h0000_1111);
        send(5'd12, 32'h0000_2222);
        send(5'd31, 32'h0000_3333);
        tick(1);
        chk("ill_cnt", {16'd0, ill_cnt}, 32'd3);
        chk("ill_lvl", {29'd0, level},   32'd0);

        // Full FIFO back-pressure, with pointer wrap
        out_ready = 1'b0;
        send(5'd1, 32'hA000_0001);
        send(5'd4, 32'hA000_0042);
        send(5'd2, 32'hA000_0083);
        send(5'd5, 32'hA000_00C4);
        chk("full_level", {29'd0, level},    32'd4);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_command = 5'd6; in_address = 32'hA000_0105;
        tick(2);
        chk("full_held", {29'd0, level}, 32'd4);
        out_ready = 1'b1;
        #1;
        chk("full_ready_oready", {31'd0, in_ready}, 32'd0);
        send(5'd6, 32'hA000_0105);
        tick(6);
        chk("full_drained", {29'd0, level}, 32'd0);

        // Clear: drain three queued records, then one clear cycle
        out_ready = 1'b0;
        send(5'd0, 32'hB000_0000);
        send(5'd1, 32'hB000_0040);
        send(5'd2, 32'hB000_0080);
        send(5'd8, 32'h0);
        chk("clr_ready0", {31'd0, in_ready}, 32'd0);
        tick(2);
        chk("clr_ready_hold", {31'd0, in_ready}, 32'd0);
        chk("clr_level_hold", {29'd0, level},    32'd3);
        out_ready = 1'b1;
        tick(6);
        chk("clr_rd",    {16'd0, rd_cnt},   32'd0);
        chk("clr_ill",   {16'd0, ill_cnt},  32'd0);
        chk("clr_ready", {31'd0, in_ready}, 32'd1);

        // Print request
        send(5'd1, 32'hC000_0000);
        send(5'd9, 32'h0);
        chk("print_hi", {31'd0, print_pulse}, 32'd1);
        tick(1);
        chk("print_lo", {31'd0, print_pulse}, 32'd0);
        chk("print_wr", {16'd0, wr_cnt},      32'd1);

        // Asynchronous reset while draining with records queued
        out_ready = 1'b0;
        send(5'd0, 32'hD000_0000);
        send(5'd3, 32'hD000_0040);
        send(5'd8, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, in_ready},    32'd0);
        chk("arst_valid", {31'd0, out_valid},   32'd0);
        chk("arst_level", {29'd0, level},       32'd0);
        chk("arst_rd",    {16'd0, rd_cnt},      32'd0);
        chk("arst_snp",   {16'd0, snp_cnt},     32'd0);
        tick(2);
        rst = 1'b0;
        #1;
        chk("arst_release", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        send(5'd4, 32'hE123_4567);
        tick(3);

        // Saturation on the 4-bit counter instance
        sat_reads(14);
        chk("sat_pre", {28'd0, s_rd_cnt}, 32'hE);
        sat_reads(3);
        chk("sat_hold", {28'd0, s_rd_cnt}, 32'hF);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
